ex_stage_md: RTL
================

Name: ex_stage_md

Overview:
Parametrised successor to the pipeline execute stage.
- Keeps the combinational forward-mux → ALU-operand-select → ALU path, with a per-operand 4-source forwarding select.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, MFHI/MFLO/MTHI/MTLO support and a stall request to the hazard unit.
- Sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
- DW, 32, datapath width (≥8, even).
- AW, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rs_data  in  DW  register operand A from ID/EX.
- rt_data  in  DW  register operand B from ID/EX.
- sign_imm  in  DW  sign-extended immediate.
- shamt  in  5  shift amount; zero-extended to DW.
- rt_addr  in  AW  destination when reg_dst=0.
- rd_addr  in  AW  destination when reg_dst=1.
- alu_src_a  in  1  1 selects shamt as ALU A.
- alu_src_b  in  1  1 selects sign_imm as ALU B.
- alu_op  in  5  ALU operation (shared package codes).
- reg_dst  in  1  destination select.
- fwd_a  in  2  00 rs_data, 01 wb_data_w, 10 alu_res_m, 11 dmem_data_m.
- fwd_b  in  2  same encoding, for rt_data.
- alu_res_m  in  DW  MEM-stage ALU result.
- wb_data_w  in  DW  WB write data.
- dmem_data_m  in  DW  MEM-stage load data.
- md_start  in  1  launch multiply/divide this cycle.
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- mf_sel  in  2  00 none, 01 MFHI, 10 MFLO, 11 reserved (treated as none).
- hilo_wr  in  2  bit1 HI←fwdA, bit0 LO←fwdA.
- zero  out  1  ALU result == 0.
- ex_res  out  DW  stage result.
- wr_addr  out  AW  selected destination.
- store_data  out  DW  forwarded B, before the immediate mux.
- md_busy  out  1  MD unit not IDLE.
- stall_req  out  1  hold IF/ID/EX.
- md_done  out  1  one-cycle pulse, HI/LO updated.
- md_dz  out  1  with md_done: divide by zero occurred.

Behaviour:
- Combinational path:
  - fwdA/fwdB = 4:1 mux on fwd_a/fwd_b.
  - ALU A = alu_src_a ? shamt : fwdA.
  - ALU B = alu_src_b ? sign_imm : fwdB.
  - store_data = fwdB.
  - wr_addr = reg_dst ? rd_addr : rt_addr.
  - ex_res = mf_sel==01 ? HI : mf_sel==10 ? LO : alu_out.
  - zero is computed from alu_out only.
- While rst_n=0: ex_res, store_data, wr_addr, zero, md_busy, stall_req, md_done and md_dz are all 0; HI=LO=0; FSM in IDLE.
- stall_req = md_busy & (md_start | mf_sel∈{01,10} | hilo_wr≠0).
- MD FSM states: IDLE, RUN, FIX.
  - IDLE→RUN on an edge with md_start=1. Latches fwdA (dividend/multiplicand), fwdB and md_op; converts signed operands to magnitudes; cnt=DW-1.
  - RUN: one radix-2 step per cycle (shift-add multiply, restoring divide). cnt decrements; at cnt==0, →FIX.
  - FIX: applies sign correction, writes HI/LO, →IDLE. md_done and md_dz are registered, high for the single cycle after the FIX edge.
  - md_busy = (state≠IDLE), combinational.
- Latency: start edge = E0. HI/LO are written at edge E(DW+1). md_busy is high in cycles E0+ through E(DW+1)−. stall_req drops in the md_done cycle; an MF in that cycle reads the new value.
- Multiply: {HI,LO} = 2DW-bit product; signed for MULT, unsigned for MULTU.
- Divide:
  - LO = quotient truncated toward zero.
  - HI = remainder carrying the dividend's sign.
  - Signed overflow (−2^(DW−1) ÷ −1): LO = −2^(DW−1), HI = 0, md_dz = 0.
  - Divide by zero: LO = all-ones, HI = dividend, md_dz = 1.
- hilo_wr takes effect on an edge only in IDLE.
  - md_start together with hilo_wr: md_start wins, hilo_wr is dropped.
  - md_start or hilo_wr while busy: ignored (upstream is stalled).
- Reset asserted mid-operation aborts immediately: state→IDLE, HI=LO=0, no md_done.

Decomposition:
- Package ex_pkg:
  - ALU op codes.
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU.
  - MF_NONE/MF_HI/MF_LO.
  - FWD_REG/FWD_WB/FWD_MEM/FWD_DMEM.
  - MD state enum.
- Sub-modules:
  - md_unit: FSM, counter, HI/LO registers, sign fix.
  - The existing ALU is instantiated unchanged.

Test Plan (DW=32):
- Forwarding: rs_data=5, fwd_a=10, alu_res_m=7, rt_data=3, alu_op=ADD → ex_res=10, store_data=3; fwd_b=11, dmem_data_m=9 → store_data=9, ex_res=16.
- MULT fwdA=0xFFFFFFFD (−3), fwdB=7 → md_busy for 33 cycles, md_done in the 34th cycle after E0, HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=1.
- DIVU 100/7 → LO=14, HI=2; DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, md_dz=0.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5, md_dz=1 during the md_done cycle.
- MFLO issued at E5 of a MULT 6×7 → stall_req=1 until the md_done cycle, then ex_res=42; MTHI issued while busy → HI unchanged.
- rst_n low for 1 cycle at RUN cycle 10 → md_busy=0 immediately, HI=LO=0, no md_done; a new DIVU 9/3 after release → LO=3, HI=0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, multiply/divide ops,
// move-from selects, forwarding selects and the multiply/divide FSM states.
package ex_pkg;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_LUI  = 5'd11;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] MF_NONE  = 2'b00;
    localparam logic [1:0] MF_HI    = 2'b01;
    localparam logic [1:0] MF_LO    = 2'b10;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_DMEM = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } mdState_t;

endpackage

// File: rtl/ex_stage_md_alu.sv
// Combinational integer ALU; zero latency, no flow control.
// Shifts take the amount from a and the value from b.
module alu #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [4:0]    op,
    output logic [DW-1:0] y
);
    import ex_pkg::*;

    localparam int SW = $clog2(DW);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: y = {{(DW-1){1'b0}}, a < b};
            ALU_SLL:  y = b << a[SW-1:0];
            ALU_SRL:  y = b >> a[SW-1:0];
            ALU_SRA:  y = $unsigned($signed(b) >>> a[SW-1:0]);
            ALU_LUI:  y = b << (DW / 2);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage_md_md_unit.sv
// Iterative radix-2 multiply/divide with HI/LO; result lands DW+1 edges after start.
// No backpressure: start/hiloWr are ignored while busy, the hazard unit must stall.
module md_unit #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [DW-1:0] opA,
    input  logic [DW-1:0] opB,
    input  logic [1:0]    hiloWr,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo,
    output logic          busy,
    output logic          done,
    output logic          dz
);
    import ex_pkg::*;

    localparam int CW = $clog2(DW);

    mdState_t      state, stateNext;
    logic [CW-1:0] cnt;
    logic          isDiv, negA, negB;
    logic [DW-1:0] magA, magB, accHi, accLo;
    logic          inNegA, inNegB;
    logic [DW-1:0] absA, absB;

    // Signed ops work on magnitudes; the sign is restored in FIX.
    assign inNegA = ~op[0] & opA[DW-1];
    assign inNegB = ~op[0] & opB[DW-1];
    assign absA   = inNegA ? -opA : opA;
    assign absB   = inNegB ? -opB : opB;
    assign busy   = (state != MD_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            MD_IDLE: if (start) stateNext = MD_RUN;
            MD_RUN:  if (cnt == '0) stateNext = MD_FIX;
            MD_FIX:  stateNext = MD_IDLE;
            default: stateNext = MD_IDLE;
        endcase
    end

    logic [DW:0]     mulSum, divShift;
    logic [DW-1:0]   divDiff;
    logic            divGe;
    logic [2*DW-1:0] prodFix;
    logic [DW-1:0]   hiFix, loFix;

    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, magA} : '0);
        divShift = {accHi, accLo[DW-1]};
        divGe    = (divShift >= {1'b0, magB});
        divDiff  = divShift[DW-1:0] - magB;
        prodFix  = (negA ^ negB) ? -{accHi, accLo} : {accHi, accLo};
        hiFix    = '0;
        loFix    = '0;
        if (!isDiv) begin
            {hiFix, loFix} = prodFix;
        end else if (magB == '0) begin
            hiFix = negA ? -magA : magA;
            loFix = '1;
        end else begin
            hiFix = negA ? -accHi : accHi;
            loFix = (negA ^ negB) ? -accLo : accLo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            isDiv <= 1'b0;
            negA  <= 1'b0;
            negB  <= 1'b0;
            magA  <= '0;
            magB  <= '0;
            accHi <= '0;
            accLo <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            dz    <= 1'b0;
        end else begin
            done <= 1'b0;
            dz   <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        isDiv <= op[1];
                        negA  <= inNegA;
                        negB  <= inNegB;
                        magA  <= absA;
                        magB  <= absB;
                        accHi <= '0;
                        accLo <= op[1] ? absA : absB;
                        cnt   <= CW'(DW - 1);
                    end else begin
                        if (hiloWr[1]) hi <= opA;
                        if (hiloWr[0]) lo <= opA;
                    end
                end
                MD_RUN: begin
                    cnt <= cnt - 1'b1;
                    // Divide shifts the dividend into the remainder; multiply shifts the product right.
                    if (isDiv) begin
                        accHi <= divGe ? divDiff : divShift[DW-1:0];
                        accLo <= {accLo[DW-2:0], divGe};
                    end else begin
                        {accHi, accLo} <= {mulSum, accLo[DW-1:1]};
                    end
                end
                MD_FIX: begin
                    hi   <= hiFix;
                    lo   <= loFix;
                    done <= 1'b1;
                    dz   <= isDiv & (magB == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding muxes, ALU and multiply/divide unit; ALU path is combinational.
// Requests an upstream stall when an MD/MF/MT op meets a busy multiply/divide unit.
module ex_stage_md #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [DW-1:0] sign_imm,
    input  logic [4:0]    shamt,
    input  logic [AW-1:0] rt_addr,
    input  logic [AW-1:0] rd_addr,
    input  logic          alu_src_a,
    input  logic          alu_src_b,
    input  logic [4:0]    alu_op,
    input  logic          reg_dst,
    input  logic [1:0]    fwd_a,
    input  logic [1:0]    fwd_b,
    input  logic [DW-1:0] alu_res_m,
    input  logic [DW-1:0] wb_data_w,
    input  logic [DW-1:0] dmem_data_m,
    input  logic          md_start,
    input  logic [1:0]    md_op,
    input  logic [1:0]    mf_sel,
    input  logic [1:0]    hilo_wr,
    output logic          zero,
    output logic [DW-1:0] ex_res,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] store_data,
    output logic          md_busy,
    output logic          stall_req,
    output logic          md_done,
    output logic          md_dz
);
    import ex_pkg::*;

    logic [DW-1:0] fwdA, fwdB, aluA, aluB, aluOut, hi, lo, exResRaw;
    logic          mdBusy;

    always_comb begin
        fwdA = rs_data;
        fwdB = rt_data;
        case (fwd_a)
            FWD_WB:   fwdA = wb_data_w;
            FWD_MEM:  fwdA = alu_res_m;
            FWD_DMEM: fwdA = dmem_data_m;
            default:  fwdA = rs_data;
        endcase
        case (fwd_b)
            FWD_WB:   fwdB = wb_data_w;
            FWD_MEM:  fwdB = alu_res_m;
            FWD_DMEM: fwdB = dmem_data_m;
            default:  fwdB = rt_data;
        endcase
    end

    assign aluA = alu_src_a ? {{(DW-5){1'b0}}, shamt} : fwdA;
    assign aluB = alu_src_b ? sign_imm : fwdB;

    alu #(.DW(DW)) uAlu (
        .a  (aluA),
        .b  (aluB),
        .op (alu_op),
        .y  (aluOut)
    );

    md_unit #(.DW(DW)) uMd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (md_op),
        .opA    (fwdA),
        .opB    (fwdB),
        .hiloWr (hilo_wr),
        .hi     (hi),
        .lo     (lo),
        .busy   (mdBusy),
        .done   (md_done),
        .dz     (md_dz)
    );

    always_comb begin
        exResRaw = aluOut;
        if (mf_sel == MF_HI)      exResRaw = hi;
        else if (mf_sel == MF_LO) exResRaw = lo;
    end

    // Combinational outputs are forced quiet while reset is held.
    assign ex_res     = rst_n ? exResRaw : '0;
    assign store_data = rst_n ? fwdB : '0;
    assign wr_addr    = rst_n ? (reg_dst ? rd_addr : rt_addr) : '0;
    assign zero       = rst_n & (aluOut == '0);
    assign md_busy    = mdBusy;
    assign stall_req  = mdBusy & (md_start | (mf_sel == MF_HI) | (mf_sel == MF_LO) | (hilo_wr != 2'b00));

endmodule
